// File: rtl/io_req_seq_if.sv
// Request-side bus of the fast-domain I/O sequencer: CPU access strobes in,
// PDS bus-master request/handshake out and back.
interface io_req_seq_if;
  logic BACT, BRW, BLDS, BUDS;
  logic IOACK, ALE1;
  logic IOREQ, IORW, IOLDS, IOUDS;
  logic IOACT, IODONE;
  logic BUSY;

  modport slave (
    input  BACT, BRW, BLDS, BUDS, IOACT, IODONE,
    output IOACK, ALE1, IOREQ, IORW, IOLDS, IOUDS, BUSY
  );

  modport master (
    output BACT, BRW, BLDS, BUDS, IOACT, IODONE,
    input  IOACK, ALE1, IOREQ, IORW, IOLDS, IOUDS, BUSY
  );
endinterface

// File: rtl/io_req_seq.sv
// Fast-side I/O request sequencer: captures CPU I/O cycles, drives the PDS
// master request port and acknowledges the CPU. Define POSTED_WRITE_EN to ack writes at capture.
module io_req_seq (
  input  logic          FCLK,
  input  logic          RES,
  io_req_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, REQ, ACT, TAIL} state_t;

`ifdef POSTED_WRITE_EN
  localparam logic POST_EN = 1'b1;
`else
  localparam logic POST_EN = 1'b0;
`endif

  state_t     state;
  logic       act_m, act_s, done_m, done_s;
  logic       capt, posted;
  logic [1:0] settle;
  logic       cap_go;

  // Synchronizers come out of reset at 0 regardless of the master; hold off
  // capture until they have sampled the real IOACT/IODONE levels.
  assign cap_go = (state == IDLE) && bus.BACT && !capt && !act_s && !done_s &&
                  (settle == 2'd2);

  always_ff @(posedge FCLK) begin
    if (RES) begin
      state     <= IDLE;
      act_m     <= 1'b0;
      act_s     <= 1'b0;
      done_m    <= 1'b0;
      done_s    <= 1'b0;
      capt      <= 1'b0;
      posted    <= 1'b0;
      settle    <= 2'd0;
      bus.IOREQ <= 1'b0;
      bus.IORW  <= 1'b1;
      bus.IOLDS <= 1'b0;
      bus.IOUDS <= 1'b0;
      bus.IOACK <= 1'b0;
      bus.ALE1  <= 1'b0;
      bus.BUSY  <= 1'b0;
    end else begin
      act_m  <= bus.IOACT;
      act_s  <= act_m;
      done_m <= bus.IODONE;
      done_s <= done_m;
      if (settle != 2'd2) settle <= settle + 2'd1;

      bus.IOACK <= 1'b0;
      bus.ALE1  <= 1'b0;
      if (!bus.BACT) capt <= 1'b0;

      case (state)
        IDLE: if (cap_go) begin
          capt      <= 1'b1;
          bus.IORW  <= bus.BRW;
          bus.IOLDS <= bus.BLDS;
          bus.IOUDS <= bus.BUDS;
          bus.ALE1  <= 1'b1;
          bus.IOREQ <= 1'b1;
          bus.BUSY  <= 1'b1;
          posted    <= POST_EN && !bus.BRW;
          bus.IOACK <= POST_EN && !bus.BRW;
          state     <= REQ;
        end
        REQ: if (act_s) begin
          bus.IOREQ <= 1'b0;
          state     <= ACT;
        end
        // BERR termination is indistinguishable here; it acks like DTACK.
        ACT: if (done_s) begin
          bus.IOACK <= !posted;
          state     <= TAIL;
        end
        TAIL: if (!act_s && !done_s) begin
          bus.BUSY <= 1'b0;
          posted   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
